// File: rtl/bcd_down_counter_3_digit_pkg.sv
// Shared constants, digit type and BCD helper functions for the
// three-digit BCD down counter.
package bcd_down_counter_3_digit_pkg;

  localparam int NUM_DIGITS = 3;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_NINE = 4'd9;

  function automatic logic bcd_legal(input bcd_digit_t d);
    return (d <= BCD_NINE);
  endfunction

  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input bcd_digit_t max_val);
    bcd_digit_t r;
    if (bcd_legal(d)) begin
      r = d;
    end else begin
      r = max_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_down_counter_3_digit_if.sv
// Control and result bundle of the BCD down counter. The master side drives
// load/en; the slave side (the counter) returns the count and its flags.
interface bcd_down_counter_3_digit_if;

  logic        load;
  logic [11:0] load_val;
  logic        en;
  logic [11:0] out;
  logic        zero;
  logic        borrow;
  logic        load_err;

  modport master (
    output load, load_val, en,
    input  out, zero, borrow, load_err
  );

  modport slave (
    input  load, load_val, en,
    output out, zero, borrow, load_err
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit register: load with clamp, decrement 9..0 with wrap to 9,
// recovery of illegal codes to 0, and a borrow-out flag while the digit is 0.
module bcd_down_digit
  import bcd_down_counter_3_digit_pkg::*;
#(
  parameter bcd_digit_t LOAD_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step,
  output bcd_digit_t digit,
  output bcd_digit_t nxt,
  output logic       borrow_out
);

  bcd_digit_t digit_r;

  // Next-state selection: load first, then illegal-code recovery, then step.
  always_comb begin
    nxt = digit_r;
    if (load) begin
      nxt = bcd_clamp(load_digit, LOAD_MAX);
    end else if (!bcd_legal(digit_r)) begin
      nxt = BCD_ZERO;
    end else if (step) begin
      if (digit_r == BCD_ZERO) begin
        nxt = BCD_NINE;
      end else begin
        nxt = digit_r - 4'd1;
      end
    end else begin
      nxt = digit_r;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_r <= BCD_ZERO;
    end else begin
      digit_r <= nxt;
    end
  end

  assign digit      = digit_r;
  assign borrow_out = (digit_r == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter_3_digit.sv
// Three-digit packed-BCD down counter (999..000) with preset load,
// terminal-zero flag, wrap/underflow borrow pulse and bad-load pulse.
module bcd_down_counter_3_digit
  import bcd_down_counter_3_digit_pkg::*;
#(
  parameter bit         WRAP     = 1'b1,
  parameter bcd_digit_t LOAD_MAX = 4'd9
) (
  input logic                          clk,
  input logic                          reset,
  bcd_down_counter_3_digit_if.slave    bus
);

  logic [NUM_DIGITS-1:0] step_s;
  logic [NUM_DIGITS-1:0] bout_s;
  bcd_digit_t            digit_s [NUM_DIGITS];
  bcd_digit_t            nxt_s   [NUM_DIGITS];
  logic                  at_zero_s;
  logic                  hold_zero_s;
  logic                  zero_next_s;
  logic                  borrow_next_s;
  logic                  bad_load_s;
  logic                  zero_r;
  logic                  borrow_r;
  logic                  load_err_r;

  assign at_zero_s = &bout_s;
  // Saturating mode freezes every digit once the count sits at 000.
  assign hold_zero_s = !WRAP && at_zero_s;

  // Synchronous borrow chain: a digit steps only when all lower digits are 0.
  always_comb begin
    step_s    = '0;
    step_s[0] = bus.en && !hold_zero_s;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      step_s[i] = step_s[i-1] && bout_s[i-1];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_down_digit #(
      .LOAD_MAX (LOAD_MAX)
    ) u_digit (
      .clk        (clk),
      .reset      (reset),
      .load       (bus.load),
      .load_digit (bus.load_val[4*g +: 4]),
      .step       (step_s[g]),
      .digit      (digit_s[g]),
      .nxt        (nxt_s[g]),
      .borrow_out (bout_s[g])
    );
  end

  // Flag next-states, derived from the same next digit values as the count.
  always_comb begin
    zero_next_s = 1'b1;
    bad_load_s  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (nxt_s[i] != BCD_ZERO) begin
        zero_next_s = 1'b0;
      end else begin
        zero_next_s = zero_next_s;
      end
      if (!bcd_legal(bus.load_val[4*i +: 4])) begin
        bad_load_s = 1'b1;
      end else begin
        bad_load_s = bad_load_s;
      end
    end
    borrow_next_s = bus.en && !bus.load && at_zero_s;
  end

  // Flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zero_r     <= 1'b1;
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      zero_r     <= zero_next_s;
      borrow_r   <= borrow_next_s;
      load_err_r <= bus.load && bad_load_s;
    end
  end

  assign bus.out      = {digit_s[2], digit_s[1], digit_s[0]};
  assign bus.zero     = zero_r;
  assign bus.borrow   = borrow_r;
  assign bus.load_err = load_err_r;

endmodule

// File: tb/tb_bcd_down_counter_3_digit.sv
// Directed bench for the BCD down counter: a vector table on a wrapping
// instance plus hand sequences for reset, saturation and a full sweep.
module tb_bcd_down_counter_3_digit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bcd_down_counter_3_digit_if bus_w ();
  bcd_down_counter_3_digit_if bus_s ();

  bcd_down_counter_3_digit #(.WRAP(1'b1), .LOAD_MAX(4'd9)) dut_w (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w.slave)
  );

  bcd_down_counter_3_digit #(.WRAP(1'b0), .LOAD_MAX(4'd9)) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [11:0] lv;
    logic        en;
    logic [11:0] q;
    logic        z;
    logic        b;
    logic        e;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int n);
    logic [11:0] r;
    r[11:8] = 4'(n / 100);
    r[7:4]  = 4'((n / 10) % 10);
    r[3:0]  = 4'(n % 10);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk    = 1'b0;
    reset  = 1'b0;
    checks = 0;
    errors = 0;
    bus_w.load = 1'b0; bus_w.load_val = 12'h000; bus_w.en = 1'b0;
    bus_s.load = 1'b0; bus_s.load_val = 12'h000; bus_s.en = 1'b0;

    vecs[0]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 12'h102, 1'b0, 12'h102, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 1'b1, 12'h101, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 12'h000, 1'b1, 12'h099, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 12'h001, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 12'h000, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 12'h000, 1'b0, 12'h999, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 12'h1A5, 1'b0, 12'h195, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 12'h000, 1'b0, 12'h195, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 12'h321, 1'b0, 12'h321, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 12'h500, 1'b1, 12'h500, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 12'hFFF, 1'b0, 12'h999, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 12'h000, 1'b1, 12'h998, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 12'h0A0, 1'b1, 12'h090, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 12'h000, 1'b1, 12'h089, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 12'h000, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 12'h000, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 12'h010, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 12'h000, 1'b1, 12'h009, 1'b0, 1'b0, 1'b0};

    // Reset state while reset is held.
    #12;
    chk("rst_out",      bus_w.out, 12'h000);
    chk("rst_zero",     {11'd0, bus_w.zero}, 12'h001);
    chk("rst_borrow",   {11'd0, bus_w.borrow}, 12'h000);
    chk("rst_load_err", {11'd0, bus_w.load_err}, 12'h000);
    chk("rst_out_sat",  bus_s.out, 12'h000);
    @(negedge clk);
    reset = 1'b1;

    // Vector table on the wrapping instance.
    for (int i = 0; i < 22; i++) begin
      bus_w.load     = vecs[i].ld;
      bus_w.load_val = vecs[i].lv;
      bus_w.en       = vecs[i].en;
      tick();
      chk($sformatf("vec%0d_out", i),      bus_w.out, vecs[i].q);
      chk($sformatf("vec%0d_zero", i),     {11'd0, bus_w.zero}, {11'd0, vecs[i].z});
      chk($sformatf("vec%0d_borrow", i),   {11'd0, bus_w.borrow}, {11'd0, vecs[i].b});
      chk($sformatf("vec%0d_load_err", i), {11'd0, bus_w.load_err}, {11'd0, vecs[i].e});
    end
    bus_w.load = 1'b0;
    bus_w.en   = 1'b0;

    // Saturating instance: enabled steps at 000 hold and pulse borrow each cycle.
    bus_s.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat%0d_out", i),    bus_s.out, 12'h000);
      chk($sformatf("sat%0d_zero", i),   {11'd0, bus_s.zero}, 12'h001);
      chk($sformatf("sat%0d_borrow", i), {11'd0, bus_s.borrow}, 12'h001);
    end
    bus_s.en = 1'b0;
    tick();
    chk("sat_idle_borrow", {11'd0, bus_s.borrow}, 12'h000);
    bus_s.load = 1'b1; bus_s.load_val = 12'h100;
    tick();
    bus_s.load = 1'b0; bus_s.en = 1'b1;
    tick();
    chk("sat_dec_out",    bus_s.out, 12'h099);
    chk("sat_dec_borrow", {11'd0, bus_s.borrow}, 12'h000);
    bus_s.en = 1'b0;

    // Asynchronous reset mid-count, observed before the next clock edge.
    bus_w.load = 1'b1; bus_w.load_val = 12'h537;
    tick();
    chk("pre_rst_out", bus_w.out, 12'h537);
    bus_w.load = 1'b0; bus_w.en = 1'b1;
    tick();
    chk("pre_rst_dec", bus_w.out, 12'h536);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out",    bus_w.out, 12'h000);
    chk("async_rst_zero",   {11'd0, bus_w.zero}, 12'h001);
    chk("async_rst_borrow", {11'd0, bus_w.borrow}, 12'h000);
    bus_w.en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("post_rst_out", bus_w.out, 12'h000);

    // Full sweep: 999 decrements from 999 reach 000.
    bus_w.load = 1'b1; bus_w.load_val = 12'h999;
    tick();
    bus_w.load = 1'b0; bus_w.en = 1'b1;
    for (int n = 998; n >= 0; n--) begin
      tick();
      chk($sformatf("sweep_%0d", n), bus_w.out, to_bcd(n));
    end
    chk("sweep_zero",   {11'd0, bus_w.zero}, 12'h001);
    chk("sweep_borrow", {11'd0, bus_w.borrow}, 12'h000);
    bus_w.en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
